// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single LC-3b memory port between fetch (reads) and MEM (loads/stores).
// Latency: grant in IDLE, request presented the next cycle, ready pulse one cycle after mem_rdy (3 cycles minimum).
// Backpressure: requesters hold req/addr/data until their ready pulse; the memory stalls the port by holding mem_rdy low.
// Build option: define ARB_RR_EN to alternate grants under contention; otherwise data has strict priority.
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch requester
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          imem_r,
  output logic [DW-1:0] instr,
  // MEM-stage requester
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_wmask,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          dmem_r,
  output logic [DW-1:0] d_rdata,
  // unified memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_wmask,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IFETCH  = 2'd1,
    ST_DACCESS = 2'd2
  } state_e;

  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  state_e          state_q, state_d;
  grant_e          last_grant_q, last_grant_d;

  logic            mem_we_q;
  logic [1:0]      mem_wmask_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            imem_r_q;
  logic            dmem_r_q;
  logic [DW-1:0]   instr_q;
  logic [DW-1:0]   d_rdata_q;

  logic            i_elig;
  logic            d_elig;
  logic            pick_i;
  logic            pick_d;
  logic            busy;
  logic            fetch_done;
  logic            data_done;
  logic            fetch_hit;

  // A requester still seeing its own pulse must not be granted again for the same access.
  assign i_elig = i_req && !imem_r_q;
  assign d_elig = d_req && !dmem_r_q;

  // A fetch is only delivered if fetch still wants the very address that was sent to memory.
  assign fetch_hit = i_req && (i_addr == mem_addr_q);

  // Arbitration: only in IDLE; contention resolved by strict data priority or round-robin.
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (d_elig && i_elig) begin
`ifdef ARB_RR_EN
        pick_d = (last_grant_q == GNT_INSTR);
        pick_i = (last_grant_q == GNT_DATA);
`else
        pick_d = 1'b1;
`endif
      end else begin
        pick_d = d_elig;
        pick_i = i_elig;
      end
    end
  end

  // Track the most recent winner; in the strict-priority build it is kept but does not steer grants.
  always_comb begin
    last_grant_d = last_grant_q;
    if (pick_d) begin
      last_grant_d = GNT_DATA;
    end else if (pick_i) begin
      last_grant_d = GNT_INSTR;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: grant from IDLE, return to IDLE on the completing edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_d) begin
          state_d = ST_DACCESS;
        end else if (pick_i) begin
          state_d = ST_IFETCH;
        end
      end
      ST_IFETCH, ST_DACCESS: begin
        if (mem_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the port is requested in every busy state; mem_rdy only counts while busy.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    fetch_done = (state_q == ST_IFETCH)  && mem_rdy;
    data_done  = (state_q == ST_DACCESS) && mem_rdy;
  end

  // Grant bookkeeping register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= GNT_INSTR;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Memory command registers: captured at grant, held untouched for the whole transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_wmask_q <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (pick_d) begin
      mem_we_q    <= d_we;
      mem_wmask_q <= d_wmask;
      mem_addr_q  <= d_addr;
      mem_wdata_q <= d_wdata;
    end else if (pick_i) begin
      // Fetches are full-word reads; write data is left as is since it is ignored on reads.
      mem_we_q    <= 1'b0;
      mem_wmask_q <= 2'b11;
      mem_addr_q  <= i_addr;
    end
  end

  // Fetch response: one-cycle pulse and registered word, dropped when fetch was redirected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_r_q <= 1'b0;
      instr_q  <= '0;
    end else begin
      imem_r_q <= 1'b0;
      if (fetch_done && fetch_hit) begin
        imem_r_q <= 1'b1;
        instr_q  <= mem_rdata;
      end
    end
  end

  // Data response: always pulses on completion; only loads update the returned word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_r_q  <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      dmem_r_q <= 1'b0;
      if (data_done) begin
        dmem_r_q <= 1'b1;
        if (!mem_we_q) begin
          d_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_req   = busy;
  assign mem_we    = mem_we_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign imem_r    = imem_r_q;
  assign instr     = instr_q;
  assign dmem_r    = dmem_r_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for mem_port_arbiter with hand-computed expectations.
// Each row drives one cycle of inputs and checks the outputs seen just after the following edge.
// Multi-cycle corners (redirect, reset abort, grant order) are written out as explicit sequences.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        imem_r;
  logic [15:0] instr;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_wmask;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        dmem_r;
  logic [15:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rdy;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.AW(16), .DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .imem_r    (imem_r),
    .instr     (instr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_wmask   (d_wmask),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .dmem_r    (dmem_r),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wmask (mem_wmask),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_wmask;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        rdy;
    logic [15:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [1:0]  e_mask;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_ir;
    logic [15:0] e_instr;
    logic        e_dr;
    logic [15:0] e_drdata;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic ir, input logic [15:0] ia,
    input logic dr, input logic dwe, input logic [1:0] dm, input logic [15:0] da, input logic [15:0] dwd,
    input logic rdy, input logic [15:0] rd,
    input logic e_req, input logic e_we, input logic [1:0] e_mask, input logic [15:0] e_addr,
    input logic [15:0] e_wdata, input logic e_ir, input logic [15:0] e_instr,
    input logic e_dr, input logic [15:0] e_drdata);
    vec_t v;
    v.rst_n = rst;   v.i_req = ir;     v.i_addr = ia;
    v.d_req = dr;    v.d_we = dwe;     v.d_wmask = dm;   v.d_addr = da; v.d_wdata = dwd;
    v.rdy = rdy;     v.rdata = rd;
    v.e_req = e_req; v.e_we = e_we;    v.e_mask = e_mask; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_ir = e_ir;   v.e_instr = e_instr; v.e_dr = e_dr;  v.e_drdata = e_drdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    rst_n     = v.rst_n;
    i_req     = v.i_req;
    i_addr    = v.i_addr;
    d_req     = v.d_req;
    d_we      = v.d_we;
    d_wmask   = v.d_wmask;
    d_addr    = v.d_addr;
    d_wdata   = v.d_wdata;
    mem_rdy   = v.rdy;
    mem_rdata = v.rdata;
  endtask

  task automatic check_row(input int idx, input vec_t v);
    chk($sformatf("row%0d mem_req", idx),   16'(mem_req),   16'(v.e_req));
    chk($sformatf("row%0d mem_we", idx),    16'(mem_we),    16'(v.e_we));
    chk($sformatf("row%0d mem_wmask", idx), 16'(mem_wmask), 16'(v.e_mask));
    chk($sformatf("row%0d mem_addr", idx),  mem_addr,       v.e_addr);
    chk($sformatf("row%0d mem_wdata", idx), mem_wdata,      v.e_wdata);
    chk($sformatf("row%0d imem_r", idx),    16'(imem_r),    16'(v.e_ir));
    chk($sformatf("row%0d instr", idx),     instr,          v.e_instr);
    chk($sformatf("row%0d dmem_r", idx),    16'(dmem_r),    16'(v.e_dr));
    chk($sformatf("row%0d d_rdata", idx),   d_rdata,        v.e_drdata);
  endtask

  vec_t        tbl[$];
  logic [15:0] gaddr[4];
  logic [15:0] gexp[4];
  logic [15:0] contend_exp;
  int          ng;
  logic        prev_req;

  initial begin
    rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_wmask = '0; d_addr = '0; d_wdata = '0; mem_rdy = 1'b0; mem_rdata = '0;

    // Reset state
    tbl.push_back(mk(0,0,16'h0,0,0,2'd0,16'h0,16'h0,0,16'h0,   0,0,2'd0,16'h0,16'h0,0,16'h0,0,16'h0));
    tbl.push_back(mk(0,0,16'h0,0,0,2'd0,16'h0,16'h0,1,16'hFFFF, 0,0,2'd0,16'h0,16'h0,0,16'h0,0,16'h0));
    // Fetch only, 0-wait: grant, complete, pulse (no regrant), regrant, second word, release
    tbl.push_back(mk(1,1,16'h3000,0,0,2'd0,16'h0,16'h0,0,16'h0,    1,0,2'd3,16'h3000,16'h0,0,16'h0,0,16'h0));
    tbl.push_back(mk(1,1,16'h3000,0,0,2'd0,16'h0,16'h0,1,16'h1234, 0,0,2'd3,16'h3000,16'h0,1,16'h1234,0,16'h0));
    tbl.push_back(mk(1,1,16'h3000,0,0,2'd0,16'h0,16'h0,0,16'h0,    0,0,2'd3,16'h3000,16'h0,0,16'h1234,0,16'h0));
    tbl.push_back(mk(1,1,16'h3000,0,0,2'd0,16'h0,16'h0,0,16'h0,    1,0,2'd3,16'h3000,16'h0,0,16'h1234,0,16'h0));
    tbl.push_back(mk(1,1,16'h3000,0,0,2'd0,16'h0,16'h0,1,16'h5678, 0,0,2'd3,16'h3000,16'h0,1,16'h5678,0,16'h0));
    tbl.push_back(mk(1,0,16'h3000,0,0,2'd0,16'h0,16'h0,0,16'h0,    0,0,2'd3,16'h3000,16'h0,0,16'h5678,0,16'h0));
    // mem_rdy while idle is ignored
    tbl.push_back(mk(1,0,16'h0,0,0,2'd0,16'h0,16'h0,1,16'h9999,    0,0,2'd3,16'h3000,16'h0,0,16'h5678,0,16'h0));
    // Contention, 2-wait: load 0x4000 first (cycles 1-3), dmem_r cycle 4, fetch 0x3002 cycles 5-7, imem_r cycle 8
    tbl.push_back(mk(1,1,16'h3002,1,0,2'd3,16'h4000,16'h0,0,16'h0,    1,0,2'd3,16'h4000,16'h0,0,16'h5678,0,16'h0));
    tbl.push_back(mk(1,1,16'h3002,1,0,2'd3,16'h4000,16'h0,0,16'h0,    1,0,2'd3,16'h4000,16'h0,0,16'h5678,0,16'h0));
    tbl.push_back(mk(1,1,16'h3002,1,0,2'd3,16'h4000,16'h0,0,16'h0,    1,0,2'd3,16'h4000,16'h0,0,16'h5678,0,16'h0));
    tbl.push_back(mk(1,1,16'h3002,1,0,2'd3,16'h4000,16'h0,1,16'hBEEF, 0,0,2'd3,16'h4000,16'h0,0,16'h5678,1,16'hBEEF));
    tbl.push_back(mk(1,1,16'h3002,0,0,2'd0,16'h0,16'h0,0,16'h0,       1,0,2'd3,16'h3002,16'h0,0,16'h5678,0,16'hBEEF));
    tbl.push_back(mk(1,1,16'h3002,0,0,2'd0,16'h0,16'h0,0,16'h0,       1,0,2'd3,16'h3002,16'h0,0,16'h5678,0,16'hBEEF));
    tbl.push_back(mk(1,1,16'h3002,0,0,2'd0,16'h0,16'h0,0,16'h0,       1,0,2'd3,16'h3002,16'h0,0,16'h5678,0,16'hBEEF));
    tbl.push_back(mk(1,1,16'h3002,0,0,2'd0,16'h0,16'h0,1,16'h4321,    0,0,2'd3,16'h3002,16'h0,1,16'h4321,0,16'hBEEF));
    tbl.push_back(mk(1,0,16'h3002,0,0,2'd0,16'h0,16'h0,0,16'h0,       0,0,2'd3,16'h3002,16'h0,0,16'h4321,0,16'hBEEF));
    // Store byte, 2-wait: command held through the waits, d_rdata untouched
    tbl.push_back(mk(1,0,16'h0,1,1,2'd2,16'h4001,16'hAB00,0,16'h0,    1,1,2'd2,16'h4001,16'hAB00,0,16'h4321,0,16'hBEEF));
    tbl.push_back(mk(1,0,16'h0,1,1,2'd2,16'h4001,16'hAB00,0,16'h0,    1,1,2'd2,16'h4001,16'hAB00,0,16'h4321,0,16'hBEEF));
    tbl.push_back(mk(1,0,16'h0,1,1,2'd2,16'h4001,16'hAB00,0,16'h0,    1,1,2'd2,16'h4001,16'hAB00,0,16'h4321,0,16'hBEEF));
    tbl.push_back(mk(1,0,16'h0,1,1,2'd2,16'h4001,16'hAB00,1,16'hFFFF, 0,1,2'd2,16'h4001,16'hAB00,0,16'h4321,1,16'hBEEF));
    tbl.push_back(mk(1,0,16'h0,0,0,2'd0,16'h0,16'h0,0,16'h0,          0,1,2'd2,16'h4001,16'hAB00,0,16'h4321,0,16'hBEEF));

    foreach (tbl[k]) begin
      apply(tbl[k]);
      step();
      check_row(k, tbl[k]);
    end

    // Redirect: fetch 0x3004 is abandoned for 0x5000 before completion
    i_req = 1'b1; i_addr = 16'h3004; d_req = 1'b0; d_we = 1'b0; mem_rdy = 1'b0;
    step();
    chk("redir grant mem_req", 16'(mem_req), 16'h1);
    chk("redir grant mem_addr", mem_addr, 16'h3004);
    i_addr = 16'h5000;
    step();
    chk("redir hold mem_addr", mem_addr, 16'h3004);
    mem_rdy = 1'b1; mem_rdata = 16'hDEAD;
    step();
    chk("redir no imem_r", 16'(imem_r), 16'h0);
    chk("redir instr kept", instr, 16'h4321);
    chk("redir idle mem_req", 16'(mem_req), 16'h0);
    mem_rdy = 1'b0;
    step();
    chk("redir regrant mem_req", 16'(mem_req), 16'h1);
    chk("redir regrant mem_addr", mem_addr, 16'h5000);
    mem_rdy = 1'b1; mem_rdata = 16'h5555;
    step();
    chk("redir new imem_r", 16'(imem_r), 16'h1);
    chk("redir new instr", instr, 16'h5555);
    i_req = 1'b0; mem_rdy = 1'b0;
    step();

    // Reset during a DACCESS wait state aborts without a pulse
    d_req = 1'b1; d_we = 1'b0; d_wmask = 2'b11; d_addr = 16'h4002; d_wdata = 16'h0;
    step();
    chk("rstabort grant mem_addr", mem_addr, 16'h4002);
    step();
    chk("rstabort wait mem_req", 16'(mem_req), 16'h1);
    rst_n = 1'b0;
    step();
    chk("rstabort mem_req", 16'(mem_req), 16'h0);
    chk("rstabort mem_we", 16'(mem_we), 16'h0);
    chk("rstabort mem_wmask", 16'(mem_wmask), 16'h0);
    chk("rstabort mem_addr", mem_addr, 16'h0);
    chk("rstabort mem_wdata", mem_wdata, 16'h0);
    chk("rstabort imem_r", 16'(imem_r), 16'h0);
    chk("rstabort instr", instr, 16'h0);
    chk("rstabort dmem_r", 16'(dmem_r), 16'h0);
    chk("rstabort d_rdata", d_rdata, 16'h0);
    rst_n = 1'b1; d_req = 1'b0; mem_rdy = 1'b1; mem_rdata = 16'h7777;
    step();
    chk("rstabort late rdy mem_req", 16'(mem_req), 16'h0);
    chk("rstabort late rdy dmem_r", 16'(dmem_r), 16'h0);
    chk("rstabort late rdy d_rdata", d_rdata, 16'h0);
    mem_rdy = 1'b0;

    // Both held continuously: the pulse-cycle block hands the port to the other side each time
    gexp[0] = 16'h4004; gexp[1] = 16'h3006; gexp[2] = 16'h4004; gexp[3] = 16'h3006;
    i_req = 1'b1; i_addr = 16'h3006; d_req = 1'b1; d_we = 1'b0; d_wmask = 2'b11; d_addr = 16'h4004;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      prev_req  = mem_req;
      mem_rdy   = mem_req;
      mem_rdata = 16'h1000 + 16'(c);
      step();
      if (mem_req && !prev_req) begin
        gaddr[ng] = mem_addr;
        ng++;
      end
    end
    chk("held grant count", 16'(ng), 16'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < ng) chk($sformatf("held grant%0d addr", k), gaddr[k], gexp[k]);
    end
    mem_rdy = 1'b1;
    step();
    i_req = 1'b0; d_req = 1'b0; mem_rdy = 1'b0;
    step();

    // Lone load makes DATA the last grant, then both arrive together in a fresh IDLE cycle
    d_req = 1'b1; d_addr = 16'h4006;
    step();
    chk("lone load mem_addr", mem_addr, 16'h4006);
    mem_rdy = 1'b1;
    step();
    chk("lone load dmem_r", 16'(dmem_r), 16'h1);
    d_req = 1'b0; mem_rdy = 1'b0;
    step();
`ifdef ARB_RR_EN
    contend_exp = 16'h3008;
`else
    contend_exp = 16'h4008;
`endif
    i_req = 1'b1; i_addr = 16'h3008; d_req = 1'b1; d_addr = 16'h4008;
    step();
    chk("contend after data mem_req", 16'(mem_req), 16'h1);
    chk("contend after data winner", mem_addr, contend_exp);
    mem_rdy = 1'b1;
    step();
    i_req = 1'b0; d_req = 1'b0; mem_rdy = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
